// File: rtl/mac_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// mac_pkg -- shared instruction encoding and saturation bounds.  Rev 1.0
// ------------------------------------------------------------------------
package mac_pkg;

  localparam int INST_W    = 2;
  localparam int INST_LOAD = 0;
  localparam int INST_EXEC = 1;

  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_sat_add.sv
`default_nettype none
// ------------------------------------------------------------------------
// mac_sat_add -- product + partial-sum adder with optional clamp.  Rev 1.0
// ------------------------------------------------------------------------
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int PROD_BW = 7,
  parameter int PSUM_BW = 8,
  parameter int SAT_EN  = 1
) (
  input  logic [PROD_BW-1:0] prod,
  input  logic [PSUM_BW-1:0] psum_in,
  output logic [PSUM_BW-1:0] sum,
  output logic               sat_flag
);

  // One guard bit is enough because the product is narrower than the sum.
  localparam int SUM_BW = PSUM_BW + 1;
  localparam logic [PSUM_BW-1:0] C_SAT_MAX = PSUM_BW'(sat_max(PSUM_BW));
  localparam logic [PSUM_BW-1:0] C_SAT_MIN = PSUM_BW'(sat_min(PSUM_BW));

  logic [SUM_BW-1:0] w_prod_ext;
  logic [SUM_BW-1:0] w_psum_ext;
  logic [SUM_BW-1:0] w_sum;
  logic              w_ov_pos;
  logic              w_ov_neg;

  assign w_prod_ext = {{(SUM_BW - PROD_BW){prod[PROD_BW-1]}}, prod};
  assign w_psum_ext = {psum_in[PSUM_BW-1], psum_in};
  assign w_sum      = w_prod_ext + w_psum_ext;
  assign w_ov_pos   = ~w_sum[SUM_BW-1] &  w_sum[PSUM_BW-1];
  assign w_ov_neg   =  w_sum[SUM_BW-1] & ~w_sum[PSUM_BW-1];

  if (SAT_EN != 0) begin : g_sat
    always_comb begin
      sum      = w_sum[PSUM_BW-1:0];
      sat_flag = 1'b0;
      if (w_ov_pos) begin
        sum      = C_SAT_MAX;
        sat_flag = 1'b1;
      end else if (w_ov_neg) begin
        sum      = C_SAT_MIN;
        sat_flag = 1'b1;
      end
    end
  end else begin : g_wrap
    assign sum      = w_sum[PSUM_BW-1:0];
    assign sat_flag = 1'b0;
  end

endmodule : mac_sat_add
`default_nettype wire

// File: rtl/mac_pe_pipe.sv
`default_nettype none
// ------------------------------------------------------------------------
// mac_pe_pipe -- pipelined weight-stationary MAC processing element.  Rev 1.0
// ------------------------------------------------------------------------
module mac_pe_pipe
  import mac_pkg::*;
#(
  parameter int A_BW    = 2,
  parameter int W_BW    = 4,
  parameter int PSUM_BW = 8,
  parameter int PIPE    = 2,
  parameter int SAT_EN  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [W_BW-1:0]     in_w,
  input  logic [INST_W-1:0]   inst_w,
  input  logic                clear_w,
  input  logic                a_signed,
  input  logic [PSUM_BW-1:0]  in_n,
  output logic [W_BW-1:0]     out_e,
  output logic [INST_W-1:0]   inst_e,
  output logic [PSUM_BW-1:0]  out_s,
  output logic                valid,
  output logic                sat_flag,
  output logic                w_loaded
);

  localparam int PROD_BW = A_BW + W_BW + 1;

  logic [W_BW-1:0]    weight_q, weight_d;
  logic               w_loaded_q, w_loaded_d;
  logic [W_BW-1:0]    out_e_q, out_e_d;
  logic [INST_W-1:0]  inst_e_q, inst_e_d;
  logic [PSUM_BW-1:0] out_s_q, out_s_d;
  logic               valid_q, valid_d;
  logic               sat_flag_q, sat_flag_d;

  logic               w_exec;
  logic [A_BW:0]      w_a_ext;
  logic [PROD_BW-1:0] w_a_wide;
  logic [PROD_BW-1:0] w_w_wide;
  logic [PROD_BW-1:0] w_prod;
  logic [PROD_BW-1:0] w_add_prod;
  logic [PSUM_BW-1:0] w_add_psum;
  logic               w_add_vld;
  logic [PSUM_BW-1:0] w_sum;
  logic               w_sat;

  assign w_exec   = inst_w[INST_EXEC];
  assign w_a_ext  = {a_signed & in_w[A_BW-1], in_w[A_BW-1:0]};
  assign w_a_wide = {{W_BW{w_a_ext[A_BW]}}, w_a_ext};
  assign w_w_wide = {{(A_BW + 1){weight_q[W_BW-1]}}, weight_q};
  // Uses the pre-edge weight, so a load in the same cycle is not yet visible.
  assign w_prod   = $signed(w_a_wide) * $signed(w_w_wide);

  always_comb begin
    out_e_d             = in_w;
    inst_e_d            = '0;
    inst_e_d[INST_EXEC] = inst_w[INST_EXEC];
    inst_e_d[INST_LOAD] = inst_w[INST_LOAD] & w_loaded_q;
    weight_d            = weight_q;
    w_loaded_d          = w_loaded_q;
    if (clear_w) begin
      weight_d   = '0;
      w_loaded_d = 1'b0;
    end else if (inst_w[INST_LOAD] && !w_loaded_q) begin
      weight_d   = in_w;
      w_loaded_d = 1'b1;
    end
  end

  if (PIPE == 1) begin : g_pipe1
    assign w_add_prod = w_prod;
    assign w_add_psum = in_n;
    assign w_add_vld  = w_exec;
  end else begin : g_pipe2
    logic [PROD_BW-1:0] prod_q, prod_d;
    logic [PSUM_BW-1:0] psum_q, psum_d;
    logic               exec_q, exec_d;

    always_comb begin
      prod_d = w_prod;
      psum_d = in_n;
      exec_d = w_exec;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        prod_q <= '0;
        psum_q <= '0;
        exec_q <= 1'b0;
      end else begin
        prod_q <= prod_d;
        psum_q <= psum_d;
        exec_q <= exec_d;
      end
    end

    assign w_add_prod = prod_q;
    assign w_add_psum = psum_q;
    assign w_add_vld  = exec_q;
  end

  mac_sat_add #(
    .PROD_BW (PROD_BW),
    .PSUM_BW (PSUM_BW),
    .SAT_EN  (SAT_EN)
  ) u_sat_add (
    .prod     (w_add_prod),
    .psum_in  (w_add_psum),
    .sum      (w_sum),
    .sat_flag (w_sat)
  );

  always_comb begin
    valid_d    = w_add_vld;
    out_s_d    = w_add_vld ? w_sum : out_s_q;
    sat_flag_d = w_add_vld ? w_sat : sat_flag_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      weight_q   <= '0;
      w_loaded_q <= 1'b0;
      out_e_q    <= '0;
      inst_e_q   <= '0;
      out_s_q    <= '0;
      valid_q    <= 1'b0;
      sat_flag_q <= 1'b0;
    end else begin
      weight_q   <= weight_d;
      w_loaded_q <= w_loaded_d;
      out_e_q    <= out_e_d;
      inst_e_q   <= inst_e_d;
      out_s_q    <= out_s_d;
      valid_q    <= valid_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  assign out_e    = out_e_q;
  assign inst_e   = inst_e_q;
  assign out_s    = out_s_q;
  assign valid    = valid_q;
  assign sat_flag = sat_flag_q;
  assign w_loaded = w_loaded_q;

endmodule : mac_pe_pipe
`default_nettype wire

// File: tb/tb_mac_pe_pipe.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_mac_pe_pipe -- directed bench: default, wrap (SAT_EN=0), PIPE=1.  Rev 1.0
// ------------------------------------------------------------------------
module tb_mac_pe_pipe;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] in_w = '0;
  logic [1:0] inst_w = '0;
  logic       clear_w = 1'b0;
  logic       a_signed = 1'b0;
  logic [7:0] in_n = '0;

  logic [3:0] d_out_e, w_out_e, p_out_e;
  logic [1:0] d_inst_e, w_inst_e, p_inst_e;
  logic [7:0] d_out_s, w_out_s, p_out_s;
  logic       d_valid, w_valid, p_valid;
  logic       d_sat, w_sat, p_sat;
  logic       d_wl, w_wl, p_wl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_pe_pipe #(.A_BW(2), .W_BW(4), .PSUM_BW(8), .PIPE(2), .SAT_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_w(in_w), .inst_w(inst_w), .clear_w(clear_w),
    .a_signed(a_signed), .in_n(in_n), .out_e(d_out_e), .inst_e(d_inst_e),
    .out_s(d_out_s), .valid(d_valid), .sat_flag(d_sat), .w_loaded(d_wl));

  mac_pe_pipe #(.A_BW(2), .W_BW(4), .PSUM_BW(8), .PIPE(2), .SAT_EN(0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .in_w(in_w), .inst_w(inst_w), .clear_w(clear_w),
    .a_signed(a_signed), .in_n(in_n), .out_e(w_out_e), .inst_e(w_inst_e),
    .out_s(w_out_s), .valid(w_valid), .sat_flag(w_sat), .w_loaded(w_wl));

  mac_pe_pipe #(.A_BW(2), .W_BW(4), .PSUM_BW(8), .PIPE(1), .SAT_EN(1)) dut_p1 (
    .clk(clk), .reset_n(reset_n), .in_w(in_w), .inst_w(inst_w), .clear_w(clear_w),
    .a_signed(a_signed), .in_n(in_n), .out_e(p_out_e), .inst_e(p_inst_e),
    .out_s(p_out_s), .valid(p_valid), .sat_flag(p_sat), .w_loaded(p_wl));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    inst_w = '0; in_w = '0; clear_w = 1'b0; a_signed = 1'b0; in_n = '0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic load_w(input logic [3:0] w);
    inst_w = 2'b01; in_w = w;
    tick();
    inst_w = 2'b00;
  endtask

  // Drives one execute; returns one edge after it is sampled.
  task automatic exec(input logic [1:0] a, input logic s, input logic [7:0] n);
    inst_w = 2'b10; in_w = {2'b00, a}; a_signed = s; in_n = n;
    tick();
    inst_w = 2'b00;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++; if (d_valid !== 1'b0 || d_out_s !== 8'h00 || d_sat !== 1'b0)
      begin errors++; $display("FAIL reset_out: valid=%b out_s=%h sat=%b want 0/00/0", d_valid, d_out_s, d_sat); end
    checks++; if (d_wl !== 1'b0 || d_out_e !== 4'h0 || d_inst_e !== 2'b00)
      begin errors++; $display("FAIL reset_fwd: w_loaded=%b out_e=%h inst_e=%b want 0/0/00", d_wl, d_out_e, d_inst_e); end
    in_w = 4'hF; inst_w = 2'b11; in_n = 8'h33;
    tick();
    checks++; if (d_out_e !== 4'h0 || d_inst_e !== 2'b00 || d_valid !== 1'b0 || d_wl !== 1'b0)
      begin errors++; $display("FAIL reset_hold: out_e=%h inst_e=%b valid=%b wl=%b want 0/00/0/0", d_out_e, d_inst_e, d_valid, d_wl); end
    reset_n = 1'b1;
    inst_w = 2'b00; in_w = '0; in_n = '0;
  endtask

  task automatic test_weight_chain();
    do_reset();
    load_w(4'b0010);
    checks++; if (d_wl !== 1'b1 || d_inst_e !== 2'b00)
      begin errors++; $display("FAIL chain_first: w_loaded=%b inst_e=%b want 1/00", d_wl, d_inst_e); end
    load_w(4'b0111);
    checks++; if (d_inst_e !== 2'b01 || d_out_e !== 4'b0111)
      begin errors++; $display("FAIL chain_fwd: inst_e=%b out_e=%b want 01/0111", d_inst_e, d_out_e); end
    exec(2'b01, 1'b1, 8'd3);
    checks++; if (d_valid !== 1'b0)
      begin errors++; $display("FAIL chain_latency: valid=%b want 0 one edge after execute", d_valid); end
    tick();
    checks++; if (d_valid !== 1'b1 || d_out_s !== 8'd5)
      begin errors++; $display("FAIL chain_keep_w: valid=%b out_s=%0d want 1/5", d_valid, d_out_s); end
  endtask

  task automatic test_signed_unsigned();
    do_reset();
    load_w(4'b0010);
    exec(2'b11, 1'b1, 8'd5);
    tick();
    checks++; if (d_valid !== 1'b1 || d_out_s !== 8'd3 || d_sat !== 1'b0)
      begin errors++; $display("FAIL signed_act: valid=%b out_s=%h sat=%b want 1/03/0", d_valid, d_out_s, d_sat); end
    do_reset();
    load_w(4'b1110);
    exec(2'b11, 1'b0, 8'd4);
    tick();
    checks++; if (d_valid !== 1'b1 || d_out_s !== 8'hFE || d_sat !== 1'b0)
      begin errors++; $display("FAIL unsigned_act: valid=%b out_s=%h sat=%b want 1/fe/0", d_valid, d_out_s, d_sat); end
  endtask

  task automatic test_saturation();
    do_reset();
    load_w(4'b0111);
    exec(2'b01, 1'b1, 8'd127);
    tick();
    checks++; if (d_out_s !== 8'h7F || d_sat !== 1'b1)
      begin errors++; $display("FAIL sat_pos: out_s=%h sat=%b want 7f/1", d_out_s, d_sat); end
    checks++; if (w_out_s !== 8'h86 || w_sat !== 1'b0 || w_valid !== 1'b1)
      begin errors++; $display("FAIL wrap_pos: out_s=%h sat=%b valid=%b want 86/0/1", w_out_s, w_sat, w_valid); end
    do_reset();
    load_w(4'b1000);
    exec(2'b11, 1'b0, 8'h88);
    tick();
    checks++; if (d_out_s !== 8'h80 || d_sat !== 1'b1)
      begin errors++; $display("FAIL sat_neg: out_s=%h sat=%b want 80/1", d_out_s, d_sat); end
    checks++; if (w_out_s !== 8'h70 || w_sat !== 1'b0)
      begin errors++; $display("FAIL wrap_neg: out_s=%h sat=%b want 70/0", w_out_s, w_sat); end
    tick();
    checks++; if (d_valid !== 1'b0 || d_out_s !== 8'h80 || d_sat !== 1'b1)
      begin errors++; $display("FAIL sat_hold: valid=%b out_s=%h sat=%b want 0/80/1", d_valid, d_out_s, d_sat); end
  endtask

  task automatic test_back_to_back();
    logic       exp_dv, exp_pv;
    logic [7:0] exp_do, exp_po;
    do_reset();
    load_w(4'b0010);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        inst_w = 2'b10; in_w = 4'b0001; a_signed = 1'b1; in_n = 8'(i);
      end else begin
        inst_w = 2'b00;
      end
      tick();
      exp_pv = (i < 3);
      exp_po = (i < 3) ? 8'(2 + i) : 8'd4;
      exp_dv = (i >= 1 && i <= 3);
      exp_do = (i == 0) ? 8'd0 : ((i <= 3) ? 8'(1 + i) : 8'd4);
      checks++; if (d_valid !== exp_dv || d_out_s !== exp_do)
        begin errors++; $display("FAIL b2b_pipe2[%0d]: valid=%b out_s=%0d want %b/%0d", i, d_valid, d_out_s, exp_dv, exp_do); end
      checks++; if (p_valid !== exp_pv || p_out_s !== exp_po)
        begin errors++; $display("FAIL b2b_pipe1[%0d]: valid=%b out_s=%0d want %b/%0d", i, p_valid, p_out_s, exp_pv, exp_po); end
    end
  endtask

  task automatic test_clear_simul();
    do_reset();
    inst_w = 2'b01; in_w = 4'b0101; clear_w = 1'b1;
    tick();
    inst_w = 2'b00; clear_w = 1'b0;
    checks++; if (d_wl !== 1'b0 || d_inst_e !== 2'b00)
      begin errors++; $display("FAIL clear_vs_load: w_loaded=%b inst_e=%b want 0/00", d_wl, d_inst_e); end
    inst_w = 2'b11; in_w = 4'b0011; a_signed = 1'b1; in_n = 8'd9;
    tick();
    inst_w = 2'b00;
    checks++; if (d_wl !== 1'b1 || d_inst_e !== 2'b10)
      begin errors++; $display("FAIL load_exec_state: w_loaded=%b inst_e=%b want 1/10", d_wl, d_inst_e); end
    tick();
    checks++; if (d_valid !== 1'b1 || d_out_s !== 8'd9)
      begin errors++; $display("FAIL load_exec_old_w: valid=%b out_s=%0d want 1/9", d_valid, d_out_s); end
    exec(2'b01, 1'b1, 8'd0);
    tick();
    checks++; if (d_out_s !== 8'd3)
      begin errors++; $display("FAIL load_exec_new_w: out_s=%0d want 3", d_out_s); end
    clear_w = 1'b1;
    tick();
    clear_w = 1'b0;
    checks++; if (d_wl !== 1'b0)
      begin errors++; $display("FAIL clear_loaded: w_loaded=%b want 0", d_wl); end
    exec(2'b01, 1'b1, 8'd7);
    tick();
    checks++; if (d_valid !== 1'b1 || d_out_s !== 8'd7)
      begin errors++; $display("FAIL exec_empty: valid=%b out_s=%0d want 1/7", d_valid, d_out_s); end
  endtask

  task automatic test_async_reset();
    do_reset();
    load_w(4'b0010);
    inst_w = 2'b10; in_w = 4'b0001; a_signed = 1'b1; in_n = 8'd10;
    tick();
    in_n = 8'd20;
    tick();
    inst_w = 2'b00;
    checks++; if (d_valid !== 1'b1 || d_out_s !== 8'd12)
      begin errors++; $display("FAIL async_pre: valid=%b out_s=%0d want 1/12", d_valid, d_out_s); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (d_valid !== 1'b0 || d_out_s !== 8'd0 || d_wl !== 1'b0)
      begin errors++; $display("FAIL async_immediate: valid=%b out_s=%0d wl=%b want 0/0/0", d_valid, d_out_s, d_wl); end
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (d_valid !== 1'b0)
        begin errors++; $display("FAIL async_flush[%0d]: valid=%b want 0", i, d_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_weight_chain();
    test_signed_unsigned();
    test_saturation();
    test_back_to_back();
    test_clear_simul();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mac_pe_pipe
`default_nettype wire
